// File: rtl/prim_subreg_upd_arb.sv
// Write scheduler for a bank of subregister slices: passes software writes through and
// round-robin arbitrates hardware updates, deferring any update that would lose to a same-cycle SW write.
module prim_subreg_upd_arb #(
   parameter int NumHw    = 4,
   parameter int NumRegs  = 16,
   parameter int AW       = 4,
   parameter int DW       = 32,
   parameter int MaxDefer = 3
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                sw_req_i,
   input  logic [AW-1:0]       sw_addr_i,
   input  logic [DW-1:0]       sw_wdata_i,
   output logic                sw_gnt_o,
   input  logic [NumHw-1:0]    hw_req_i,
   input  logic [NumHw*AW-1:0] hw_addr_i,
   input  logic [NumHw*DW-1:0] hw_data_i,
   output logic [NumHw-1:0]    hw_gnt_o,
   output logic [NumRegs-1:0]  reg_we_o,
   output logic [DW-1:0]       reg_wd_o,
   output logic [NumRegs-1:0]  reg_de_o,
   output logic [DW-1:0]       reg_d_o,
   output logic                addr_err_o
);

   localparam int          PW    = (NumHw > 1) ? $clog2(NumHw) : 1;
   localparam logic [AW:0] NREGS = NumRegs[AW:0];

   logic [PW-1:0]      rr_q, rr_d;
   logic [3:0]         defer_q, defer_d;
   logic               stall_q, stall_d;

   logic               cand_vld;
   logic [PW-1:0]      cand_idx;
   logic [AW-1:0]      cand_addr;
   logic [DW-1:0]      cand_data;
   int                 idx;
   logic               sw_gnt, collision, hw_gnt_vld;
   logic               sw_oor, hw_oor;
   logic [NumRegs-1:0] we_d, de_d;

   // First requester at or after the RR pointer; the loop runs backwards so the nearest one wins.
   always_comb begin
      cand_vld = 1'b0;
      cand_idx = '0;
      idx      = 0;
      for (int k = NumHw - 1; k >= 0; k--) begin
         idx = (int'(rr_q) + k) % NumHw;
         if (hw_req_i[idx]) begin
            cand_vld = 1'b1;
            cand_idx = PW'(idx);
         end
      end
   end

   assign cand_addr = hw_addr_i[int'(cand_idx)*AW +: AW];
   assign cand_data = hw_data_i[int'(cand_idx)*DW +: DW];

   assign sw_gnt     = sw_req_i & ~stall_q & ~rst_i;
   assign collision  = cand_vld & sw_gnt & (cand_addr == sw_addr_i);
   assign hw_gnt_vld = cand_vld & ~collision & ~rst_i;
   assign sw_gnt_o   = sw_gnt;

   assign sw_oor = ({1'b0, sw_addr_i} >= NREGS);
   assign hw_oor = ({1'b0, cand_addr} >= NREGS);

   for (genvar gi = 0; gi < NumHw; gi++) begin : g_hw_gnt
      assign hw_gnt_o[gi] = hw_gnt_vld & (cand_idx == PW'(gi));
   end

   // Out-of-range indices match no bit, so their enable vectors stay zero.
   for (genvar gi = 0; gi < NumRegs; gi++) begin : g_enables
      assign we_d[gi] = sw_gnt & (sw_addr_i == AW'(gi));
      assign de_d[gi] = hw_gnt_vld & (cand_addr == AW'(gi));
   end

   always_comb begin
      rr_d    = rr_q;
      defer_d = defer_q;
      stall_d = 1'b0;
      if (hw_gnt_vld) begin
         defer_d = '0;
         rr_d    = (cand_idx == PW'(NumHw - 1)) ? '0 : cand_idx + 1'b1;
      end else if (collision) begin
         defer_d = defer_q + 4'd1;
         stall_d = ((defer_q + 4'd1) == 4'(MaxDefer));
      end else if (!cand_vld) begin
         defer_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_q       <= '0;
         defer_q    <= '0;
         stall_q    <= 1'b0;
         reg_we_o   <= '0;
         reg_wd_o   <= '0;
         reg_de_o   <= '0;
         reg_d_o    <= '0;
         addr_err_o <= 1'b0;
      end else begin
         rr_q       <= rr_d;
         defer_q    <= defer_d;
         stall_q    <= stall_d;
         reg_we_o   <= we_d;
         reg_de_o   <= de_d;
         addr_err_o <= (sw_gnt & sw_oor) | (hw_gnt_vld & hw_oor);
         if (sw_gnt) begin
            reg_wd_o <= sw_wdata_i;
         end
         if (hw_gnt_vld) begin
            reg_d_o <= cand_data;
         end
      end
   end

endmodule

// File: tb/tb_prim_subreg_upd_arb.sv
// Scoreboard bench for prim_subreg_upd_arb: stimulus queues expected grants/enables,
// a negedge monitor pops and compares them against the DUT.
module tb_prim_subreg_upd_arb;

   localparam int NumHw    = 4;
   localparam int NumRegs  = 12;
   localparam int AW       = 4;
   localparam int DW       = 32;
   localparam int MaxDefer = 3;

   localparam logic [127:0] HD = {32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
   localparam logic [15:0]  A_RR = {4'd3, 4'd2, 4'd1, 4'd0};
   localparam logic [15:0]  A_H0_2 = {4'd0, 4'd0, 4'd0, 4'd2};

   logic                clk = 1'b0;
   logic                rst;
   logic                sw_req;
   logic [AW-1:0]       sw_addr;
   logic [DW-1:0]       sw_wdata;
   logic                sw_gnt;
   logic [NumHw-1:0]    hw_req;
   logic [NumHw*AW-1:0] hw_addr;
   logic [NumHw*DW-1:0] hw_data;
   logic [NumHw-1:0]    hw_gnt;
   logic [NumRegs-1:0]  reg_we;
   logic [DW-1:0]       reg_wd;
   logic [NumRegs-1:0]  reg_de;
   logic [DW-1:0]       reg_d;
   logic                addr_err;

   typedef struct {
      int         due;
      logic       sg;
      logic [3:0] hg;
   } gnt_t;

   typedef struct {
      int          due;
      logic [11:0] we;
      logic [31:0] wd;
      logic        chk_wd;
      logic [11:0] de;
      logic [31:0] d;
      logic        chk_d;
      logic        err;
   } out_t;

   gnt_t gnt_q[$];
   out_t out_q[$];
   int   cyc   = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   prim_subreg_upd_arb #(
      .NumHw(NumHw), .NumRegs(NumRegs), .AW(AW), .DW(DW), .MaxDefer(MaxDefer)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .sw_req_i(sw_req), .sw_addr_i(sw_addr), .sw_wdata_i(sw_wdata), .sw_gnt_o(sw_gnt),
      .hw_req_i(hw_req), .hw_addr_i(hw_addr), .hw_data_i(hw_data), .hw_gnt_o(hw_gnt),
      .reg_we_o(reg_we), .reg_wd_o(reg_wd), .reg_de_o(reg_de), .reg_d_o(reg_d),
      .addr_err_o(addr_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   // Drive one cycle of inputs and queue the hand-computed grants (this cycle) and enables (next cycle).
   task automatic step(input logic rst_v, input logic sreq, input logic [3:0] saddr,
                       input logic [31:0] swd, input logic [3:0] hreq, input logic [15:0] haddr,
                       input logic [127:0] hdata, input logic e_sg, input logic [3:0] e_hg,
                       input logic [11:0] e_we, input logic [11:0] e_de, input logic e_err);
      gnt_t g;
      out_t o;
      rst      = rst_v;
      sw_req   = sreq;
      sw_addr  = saddr;
      sw_wdata = swd;
      hw_req   = hreq;
      hw_addr  = haddr;
      hw_data  = hdata;
      g.due = cyc;
      g.sg  = e_sg;
      g.hg  = e_hg;
      gnt_q.push_back(g);
      o.due    = cyc + 1;
      o.we     = e_we;
      o.de     = e_de;
      o.err    = e_err;
      o.wd     = rst_v ? 32'h0 : swd;
      o.chk_wd = rst_v | e_sg;
      o.d      = 32'h0;
      o.chk_d  = rst_v;
      for (int i = 0; i < NumHw; i++) begin
         if (e_hg[i]) begin
            o.d     = hdata[i*32 +: 32];
            o.chk_d = 1'b1;
         end
      end
      out_q.push_back(o);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 4'd0, 32'h0, 4'b0000, 16'h0, 128'h0, 1'b0, 4'b0000, 12'h000, 12'h000, 1'b0);
   endtask

   // Monitor: compares grants every scheduled cycle and slice enables when they fall due.
   initial begin
      gnt_t g;
      out_t o;
      forever begin
         @(negedge clk);
         if (gnt_q.size() > 0 && gnt_q[0].due == cyc) begin
            g = gnt_q.pop_front();
            check("sw_gnt", 64'(sw_gnt), 64'(g.sg));
            check("hw_gnt", 64'(hw_gnt), 64'(g.hg));
         end
         if (out_q.size() > 0 && out_q[0].due == cyc) begin
            o = out_q.pop_front();
            $display("cyc %0d: we=%03h wd=%08h de=%03h d=%08h err=%b", cyc, reg_we, reg_wd,
                     reg_de, reg_d, addr_err);
            check("reg_we", 64'(reg_we), 64'(o.we));
            check("reg_de", 64'(reg_de), 64'(o.de));
            check("addr_err", 64'(addr_err), 64'(o.err));
            if (o.chk_wd) check("reg_wd", 64'(reg_wd), 64'(o.wd));
            if (o.chk_d) check("reg_d", 64'(reg_d), 64'(o.d));
         end else if (reg_we != '0 || reg_de != '0 || addr_err) begin
            check("unexpected_out", {reg_we, reg_de, 31'h0, addr_err}, 64'h0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; sw_req = 1'b0; sw_addr = '0; sw_wdata = '0;
      hw_req = '0; hw_addr = '0; hw_data = '0;
      @(posedge clk);
      #1;

      // Reset held with every requester active: nothing granted, outputs cleared.
      repeat (3) step(1'b1, 1'b1, 4'd1, 32'h1111_1111, 4'b1111, A_RR, HD,
                      1'b0, 4'b0000, 12'h000, 12'h000, 1'b0);

      // Round robin over four HW requesters.
      step(1'b0, 1'b0, 4'd0, 32'h0, 4'b1111, A_RR, HD, 1'b0, 4'b0001, 12'h000, 12'h001, 1'b0);
      step(1'b0, 1'b0, 4'd0, 32'h0, 4'b1111, A_RR, HD, 1'b0, 4'b0010, 12'h000, 12'h002, 1'b0);
      step(1'b0, 1'b0, 4'd0, 32'h0, 4'b1111, A_RR, HD, 1'b0, 4'b0100, 12'h000, 12'h004, 1'b0);
      step(1'b0, 1'b0, 4'd0, 32'h0, 4'b1111, A_RR, HD, 1'b0, 4'b1000, 12'h000, 12'h008, 1'b0);
      step(1'b0, 1'b0, 4'd0, 32'h0, 4'b1111, A_RR, HD, 1'b0, 4'b0001, 12'h000, 12'h001, 1'b0);

      // Parallel SW reg 5 and HW1 reg 7.
      step(1'b0, 1'b1, 4'd5, 32'hDEAD_BEEF, 4'b0010, {4'd0, 4'd0, 4'd7, 4'd0},
           {32'h0, 32'h0, 32'h1234_5678, 32'h0}, 1'b1, 4'b0010, 12'h020, 12'h080, 1'b0);
      idle();

      // Starvation: three deferrals, then a stall cycle that forces the HW grant.
      step(1'b0, 1'b1, 4'd2, 32'hA1, 4'b0001, A_H0_2, HD, 1'b1, 4'b0000, 12'h004, 12'h000, 1'b0);
      step(1'b0, 1'b1, 4'd2, 32'hA2, 4'b0001, A_H0_2, HD, 1'b1, 4'b0000, 12'h004, 12'h000, 1'b0);
      step(1'b0, 1'b1, 4'd2, 32'hA3, 4'b0001, A_H0_2, HD, 1'b1, 4'b0000, 12'h004, 12'h000, 1'b0);
      step(1'b0, 1'b1, 4'd2, 32'hA4, 4'b0001, A_H0_2, HD, 1'b0, 4'b0001, 12'h000, 12'h004, 1'b0);
      step(1'b0, 1'b1, 4'd2, 32'hA4, 4'b0000, A_H0_2, HD, 1'b1, 4'b0000, 12'h004, 12'h000, 1'b0);

      // A cycle without HW request clears the deferral count: no stall after four collisions.
      step(1'b0, 1'b1, 4'd2, 32'hB1, 4'b0001, A_H0_2, HD, 1'b1, 4'b0000, 12'h004, 12'h000, 1'b0);
      step(1'b0, 1'b1, 4'd2, 32'hB2, 4'b0001, A_H0_2, HD, 1'b1, 4'b0000, 12'h004, 12'h000, 1'b0);
      step(1'b0, 1'b1, 4'd2, 32'hB3, 4'b0000, A_H0_2, HD, 1'b1, 4'b0000, 12'h004, 12'h000, 1'b0);
      step(1'b0, 1'b1, 4'd2, 32'hB4, 4'b0001, A_H0_2, HD, 1'b1, 4'b0000, 12'h004, 12'h000, 1'b0);
      step(1'b0, 1'b1, 4'd2, 32'hB5, 4'b0001, A_H0_2, HD, 1'b1, 4'b0000, 12'h004, 12'h000, 1'b0);
      step(1'b0, 1'b0, 4'd2, 32'h0, 4'b0001, A_H0_2, HD, 1'b0, 4'b0001, 12'h000, 12'h004, 1'b0);

      // Out-of-range indices (>= 12) complete the handshake and flag addr_err only.
      step(1'b0, 1'b1, 4'd13, 32'h5A5A_5A5A, 4'b0000, 16'h0, HD, 1'b1, 4'b0000, 12'h000, 12'h000, 1'b1);
      step(1'b0, 1'b0, 4'd0, 32'h0, 4'b0001, {4'd0, 4'd0, 4'd0, 4'd12}, HD, 1'b0, 4'b0001, 12'h000, 12'h000, 1'b1);
      step(1'b0, 1'b1, 4'd13, 32'h6B6B_6B6B, 4'b0001, {4'd0, 4'd0, 4'd0, 4'd13}, HD, 1'b1, 4'b0000, 12'h000, 12'h000, 1'b1);
      step(1'b0, 1'b0, 4'd0, 32'h0, 4'b0001, {4'd0, 4'd0, 4'd0, 4'd13}, HD, 1'b0, 4'b0001, 12'h000, 12'h000, 1'b1);
      idle();

      // Reset in the stall cycle, then the count restarts from one.
      step(1'b0, 1'b1, 4'd2, 32'hC1, 4'b0001, A_H0_2, HD, 1'b1, 4'b0000, 12'h004, 12'h000, 1'b0);
      step(1'b0, 1'b1, 4'd2, 32'hC2, 4'b0001, A_H0_2, HD, 1'b1, 4'b0000, 12'h004, 12'h000, 1'b0);
      step(1'b0, 1'b1, 4'd2, 32'hC3, 4'b0001, A_H0_2, HD, 1'b1, 4'b0000, 12'h004, 12'h000, 1'b0);
      step(1'b1, 1'b1, 4'd2, 32'hC4, 4'b0001, A_H0_2, HD, 1'b0, 4'b0000, 12'h000, 12'h000, 1'b0);
      step(1'b0, 1'b1, 4'd2, 32'hD1, 4'b0001, A_H0_2, HD, 1'b1, 4'b0000, 12'h004, 12'h000, 1'b0);
      step(1'b0, 1'b1, 4'd2, 32'hD2, 4'b0001, A_H0_2, HD, 1'b1, 4'b0000, 12'h004, 12'h000, 1'b0);
      step(1'b0, 1'b1, 4'd2, 32'hD3, 4'b0001, A_H0_2, HD, 1'b1, 4'b0000, 12'h004, 12'h000, 1'b0);
      step(1'b0, 1'b1, 4'd2, 32'hD4, 4'b0001, A_H0_2, HD, 1'b0, 4'b0001, 12'h000, 12'h004, 1'b0);
      idle();
      idle();

      @(negedge clk);
      #1;
      check("queues_drained", 64'(gnt_q.size() + out_q.size()), 64'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
